// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types for the ARM core: scoreboard slot layout and forwarding encodings.
package arm_pipe_pkg;

    // Slot dest field is sized for the widest register index any core variant uses.
    localparam int SB_REG_W    = 8;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic                wb_en;
        logic [SB_REG_W-1:0] dest;
        logic                mem_read;
    } sb_slot_t;

    localparam sb_slot_t BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side hazard handshake: instruction descriptor in, stall and forwarding selects out.
interface hazard_scoreboard_if #(
    parameter int REG_W = 4,
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) ();
    logic             freeze;
    logic             flush;
    logic             id_valid;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_src1_used;
    logic             id_src2_used;
    logic             id_wb_en;
    logic [REG_W-1:0] id_dest;
    logic             id_mem_read;
    logic             stall;
    logic [SEL_W-1:0] fwd_sel1;
    logic [SEL_W-1:0] fwd_sel2;
    logic [CNT_W-1:0] pending;

    modport master (
        output freeze, flush, id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_wb_en, id_dest, id_mem_read,
        input  stall, fwd_sel1, fwd_sel2, pending
    );

    modport slave (
        input  freeze, flush, id_valid, id_src1, id_src2, id_src1_used, id_src2_used,
               id_wb_en, id_dest, id_mem_read,
        output stall, fwd_sel1, fwd_sel2, pending
    );
endinterface

// File: rtl/hazard_scoreboard_src_match.sv
// Compares one ID source against the in-flight writers; the WB slot is excluded because
// the register file writes through.
module src_match
    import arm_pipe_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int DEPTH = 3,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  sb_slot_t [DEPTH-1:0] slots,
    input  logic [REG_W-1:0]     src,
    input  logic                 used,
    output logic                 hit_any,
    output logic                 load_hit0,
    output logic [SEL_W-1:0]     sel
);
    logic [DEPTH-2:0] match;

    always_comb begin
        match     = '0;
        hit_any   = 1'b0;
        load_hit0 = 1'b0;
        sel       = SEL_W'(FWD_REGFILE);
        for (int i = 0; i < DEPTH - 1; i++) begin
            match[i] = used & slots[i].valid & slots[i].wb_en
                     & (slots[i].dest == SB_REG_W'(src));
        end
        hit_any   = |match;
        load_hit0 = match[0] & slots[0].mem_read;
        // Walk oldest to youngest so the youngest producer wins.
        for (int i = DEPTH - 2; i >= 0; i--) begin
            if (match[i]) sel = SEL_W'(i + 1);
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Shifting scoreboard of in-flight register writes between EXE and WB; raises stall for
// the ID instruction and registers EXE forwarding selects.
module hazard_scoreboard
    import arm_pipe_pkg::*;
#(
    parameter int REG_W  = 4,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int SEL_W  = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    hazard_scoreboard_if.slave sb
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_slot_t [DEPTH-1:0] slot_q, slot_d;
    logic [SEL_W-1:0]     fwd_sel1_q, fwd_sel1_d;
    logic [SEL_W-1:0]     fwd_sel2_q, fwd_sel2_d;
    logic [CNT_W-1:0]     pending_q, pending_d;

    logic             hit1, hit2, load_hit1, load_hit2;
    logic [SEL_W-1:0] sel1, sel2;
    logic             stall, issue;

    src_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match1 (
        .slots(slot_q), .src(sb.id_src1), .used(sb.id_src1_used),
        .hit_any(hit1), .load_hit0(load_hit1), .sel(sel1)
    );

    src_match #(.REG_W(REG_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_match2 (
        .slots(slot_q), .src(sb.id_src2), .used(sb.id_src2_used),
        .hit_any(hit2), .load_hit0(load_hit2), .sel(sel2)
    );

    // Deliberately independent of flush/freeze so the IF/ID freeze path stays short.
    assign stall = sb.id_valid & ((FWD_EN != 0) ? (load_hit1 | load_hit2) : (hit1 | hit2));
    assign issue = sb.id_valid & ~stall & ~sb.flush;

    always_comb begin
        slot_d     = slot_q;
        fwd_sel1_d = fwd_sel1_q;
        fwd_sel2_d = fwd_sel2_q;
        pending_d  = pending_q;
        if (!sb.freeze) begin
            for (int i = DEPTH - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
            if (issue) begin
                slot_d[0] = '{valid: 1'b1, wb_en: sb.id_wb_en,
                              dest: SB_REG_W'(sb.id_dest), mem_read: sb.id_mem_read};
            end else begin
                slot_d[0] = BUBBLE;
            end
            fwd_sel1_d = (issue && FWD_EN != 0) ? sel1 : SEL_W'(FWD_REGFILE);
            fwd_sel2_d = (issue && FWD_EN != 0) ? sel2 : SEL_W'(FWD_REGFILE);
            pending_d  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                pending_d = pending_d + CNT_W'(slot_d[i].valid & slot_d[i].wb_en);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q     <= '0;
            fwd_sel1_q <= SEL_W'(FWD_REGFILE);
            fwd_sel2_q <= SEL_W'(FWD_REGFILE);
            pending_q  <= '0;
        end else begin
            slot_q     <= slot_d;
            fwd_sel1_q <= fwd_sel1_d;
            fwd_sel2_q <= fwd_sel2_d;
            pending_q  <= pending_d;
        end
    end

    assign sb.stall    = stall;
    assign sb.fwd_sel1 = fwd_sel1_q;
    assign sb.fwd_sel2 = fwd_sel2_q;
    assign sb.pending  = pending_q;
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding-control unit for the pipelined ARM core. It tracks every in-flight register write between ID and WB in a shifting scoreboard and raises `stall` when the ID-stage instruction cannot issue. When forwarding is enabled, it also produces registered forwarding selects aligned with the instruction in EXE. It sits beside IDSTAGE: `stall` drives the IF freeze, the IF2ID freeze and the ID `hazard` bubble input, and `fwd_sel1`/`fwd_sel2` drive the EXE operand muxes.

## Interface
- REG_W, 4, register-index width
- DEPTH, 3, tracked stages after ID (slot 0 = EXE … slot DEPTH-1 = WB); legal 2..8
- FWD_EN, 1, 1 = forwarding with load-use stall only; 0 = stall on every RAW match
- SEL_W, $clog2(DEPTH), forwarding-select width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- freeze  in  1  global hold (memory wait); all state holds
- flush  in  1  branch taken; the ID instruction is killed
- id_valid  in  1  ID holds a real instruction
- id_src1, id_src2  in  REG_W  source register indices
- id_src1_used, id_src2_used  in  1  source is actually read
- id_wb_en  in  1  ID instruction writes a register
- id_dest  in  REG_W  destination index
- id_mem_read  in  1  ID instruction is a load
- stall  out  1  combinational; ID must not issue this cycle
- fwd_sel1, fwd_sel2  out  SEL_W  registered; 0 = register-file value, k = result of the stage k positions past EXE
- pending  out  $clog2(DEPTH+1)  registered count of valid slots with wb_en

## Operation
- Slot state: valid, wb_en, dest, mem_read. Slot i = instruction i+1 stages past ID.
- The register file is write-through, so slot DEPTH-1 (WB) never creates a hazard. Only slots 0..DEPTH-2 are compared.
- match(i,s): s_used & slot[i].valid & slot[i].wb_en & slot[i].dest==s. This is evaluated for both sources. Sources with used=0 never match.
- With FWD_EN=0: stall = id_valid & any match in slots 0..DEPTH-2.
- With FWD_EN=1: stall = id_valid & match(0,·) & slot[0].mem_read.
- Forward select for each source is the youngest match: the lowest i gives sel = i+1; no match gives 0. It is always 0 when FWD_EN=0.
- Priority per cycle is freeze > flush > stall > issue:
  - freeze: all slots, fwd_sel and pending hold.
  - flush or stall: slots shift (slot[i] <= slot[i-1]); slot 0 <= bubble (valid=0); fwd_sel <= 0.
  - issue (id_valid, no stall, no flush): shift; slot 0 <= {1, id_wb_en, id_dest, id_mem_read}; fwd_sel <= computed selects.
  - id_valid=0 and no freeze: shift in a bubble.
- pending is recomputed from the next slot state.

## Timing
- Reset values: all slots invalid, fwd_sel1=fwd_sel2=0, pending=0, stall=0 (no slot valid).
- stall is a 0-cycle combinational function of the ID inputs and the current slots. There is no combinational path from flush or freeze to stall.
- fwd_sel is valid in the cycle the consumer occupies EXE, which is 1 cycle after issue.
- Load-use (FWD_EN=1): exactly 1 stall cycle. On the next cycle the load is in slot 1 and the select is 2.
- With FWD_EN=0, a dependent instruction stalls until its producer reaches WB: at most DEPTH-1 cycles.
- Reset asserted mid-stream clears all slots immediately. Pending hazards are lost by design, because the pipeline registers reset too.
- flush together with freeze: freeze wins. The branch stays held, so flush is still asserted on the next unfrozen cycle.

## Structure
- Shared package `arm_pipe_pkg` holds:
  - the slot struct `sb_slot_t`;
  - `FWD_REGFILE = 0`;
  - `BUBBLE` (the all-zero slot).
- The pipeline registers and the WB mux reuse `FWD_REGFILE`.
- One sub-module, `src_match`, instantiated once per source. It is combinational: it takes the slot vector and one source, and returns {hit_any, load_hit0, youngest_sel}.
- The scoreboard shift register and the select registers stay in the top module.

## Test plan
- Reset check, all parameters: assert rst asynchronously mid-cycle → slots clear at once, pending=0, fwd_sel=0, stall=0.
- ALU chain, FWD_EN=1, DEPTH=3: ADD r1 then SUB r2,r1,r3 back-to-back → no stall; fwd_sel1=1 in the SUB EXE cycle. With one NOP between them → fwd_sel1=2.
- Load-use, FWD_EN=1: LDR r4 then ADD r5,r4,r4 → stall=1 for exactly 1 cycle with a bubble in slot 0; then fwd_sel1=fwd_sel2=2.
- No forwarding, FWD_EN=0, DEPTH=5: ADD r1 then a dependent ORR r1 → stall for 4 cycles; issues with fwd_sel=0 once the producer reaches WB.
- Flush and freeze:
  - Load-use stall coinciding with flush → slot 0 bubble, no issue, stall drops on the next cycle.
  - Freeze held 3 cycles → slots, fwd_sel and pending unchanged.
- Unused source: STR/CMP with src2_used=0 and src2 matching a pending dest → no stall, fwd_sel2=0.
